// File: rtl/stg4ma_pkg.sv
// Shared widths, opcodes and state encoding for the memory-access stage.
package stg4ma_pkg;

    localparam int unsigned SIZE_DATA   = 24;
    localparam int unsigned SIZE_ADDR   = 24;
    localparam int unsigned SIZE_OPC    = 8;
    localparam int unsigned SIZE_TGT_GP = 4;
    localparam int unsigned SIZE_TGT_SR = 2;

    localparam logic [SIZE_OPC-1:0] OPC_NOP  = 8'h00;
    localparam logic [SIZE_OPC-1:0] OPC_M_LD = 8'h30;
    localparam logic [SIZE_OPC-1:0] OPC_M_ST = 8'h31;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StFault = 2'd2
    } state_e;

    function automatic logic is_mem_op(input logic [SIZE_OPC-1:0] opc);
        return (opc == OPC_M_LD) || (opc == OPC_M_ST);
    endfunction

endpackage

// File: rtl/stg4ma_timeout_ctr.sv
// Wait-cycle counter for a memory transaction; expired flags the last allowed cycle.
module ma_timeout_ctr #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/stg4ma.sv
// Memory-access pipeline stage: passes ALU ops through, runs LD/ST on the data port.
module stg4ma
    import stg4ma_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                   iw_clk,
    input  logic                   iw_rst,
    input  logic [SIZE_ADDR-1:0]   iw_pc,
    input  logic [SIZE_DATA-1:0]   iw_instr,
    input  logic [SIZE_OPC-1:0]    iw_opc,
    input  logic [SIZE_TGT_GP-1:0] iw_tgt_gp,
    input  logic [SIZE_TGT_SR-1:0] iw_tgt_sr,
    input  logic [SIZE_DATA-1:0]   iw_result,
    input  logic [SIZE_DATA-1:0]   iw_st_data,
    output logic [SIZE_ADDR-1:0]   ow_pc,
    output logic [SIZE_DATA-1:0]   ow_instr,
    output logic [SIZE_OPC-1:0]    ow_opc,
    output logic [SIZE_TGT_GP-1:0] ow_tgt_gp,
    output logic [SIZE_TGT_SR-1:0] ow_tgt_sr,
    output logic [SIZE_DATA-1:0]   ow_result,
    output logic                   ow_stall,
    output logic                   ow_fault,
    output logic                   ow_mem_req,
    output logic                   ow_mem_we,
    output logic [SIZE_ADDR-1:0]   ow_mem_addr,
    output logic [SIZE_DATA-1:0]   ow_mem_wdata,
    input  logic                   iw_mem_ack,
    input  logic [SIZE_DATA-1:0]   iw_mem_rdata
);

    state_e state_q, state_d;

    logic [SIZE_ADDR-1:0]   pc_q, pc_d;
    logic [SIZE_DATA-1:0]   instr_q, instr_d;
    logic [SIZE_OPC-1:0]    opc_q, opc_d;
    logic [SIZE_TGT_GP-1:0] tgt_gp_q, tgt_gp_d;
    logic [SIZE_TGT_SR-1:0] tgt_sr_q, tgt_sr_d;
    logic [SIZE_DATA-1:0]   result_q, result_d;
    logic                   fault_q, fault_d;
    logic                   req_q, req_d;
    logic                   we_q, we_d;
    logic [SIZE_ADDR-1:0]   addr_q, addr_d;
    logic [SIZE_DATA-1:0]   wdata_q, wdata_d;

    logic stall;
    logic ctr_clr, ctr_en, ctr_expired;
    logic ack;

    // Ack is only meaningful while a request is outstanding.
    assign ack = iw_mem_ack && req_q;

    ma_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk     (iw_clk),
        .rst     (iw_rst),
        .clr     (ctr_clr),
        .en      (ctr_en),
        .expired (ctr_expired)
    );

    // Next-state, pipeline latch values, memory port and stall.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        opc_d    = opc_q;
        tgt_gp_d = tgt_gp_q;
        tgt_sr_d = tgt_sr_q;
        result_d = result_q;
        fault_d  = 1'b0;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        stall    = 1'b0;
        ctr_clr  = 1'b0;
        ctr_en   = 1'b0;

        case (state_q)
            StIdle: begin
                pc_d    = iw_pc;
                instr_d = iw_instr;
                ctr_clr = 1'b1;
                if (is_mem_op(iw_opc)) begin
                    stall    = 1'b1;
                    opc_d    = OPC_NOP;
                    tgt_gp_d = '0;
                    tgt_sr_d = '0;
                    result_d = '0;
                    req_d    = 1'b1;
                    we_d     = (iw_opc == OPC_M_ST);
                    addr_d   = iw_result[SIZE_ADDR-1:0];
                    wdata_d  = iw_st_data;
                    state_d  = StWait;
                end else begin
                    opc_d    = iw_opc;
                    tgt_gp_d = iw_tgt_gp;
                    tgt_sr_d = iw_tgt_sr;
                    result_d = iw_result;
                end
            end
            StWait: begin
                pc_d    = iw_pc;
                instr_d = iw_instr;
                if (ack) begin
                    // Ack beats a simultaneous timeout.
                    opc_d    = iw_opc;
                    tgt_gp_d = iw_tgt_gp;
                    tgt_sr_d = iw_tgt_sr;
                    result_d = (iw_opc == OPC_M_LD) ? iw_mem_rdata : iw_result;
                    req_d    = 1'b0;
                    we_d     = 1'b0;
                    state_d  = StIdle;
                end else begin
                    stall    = 1'b1;
                    opc_d    = OPC_NOP;
                    tgt_gp_d = '0;
                    tgt_sr_d = '0;
                    result_d = '0;
                    ctr_en   = 1'b1;
                    if (ctr_expired) begin
                        req_d   = 1'b0;
                        we_d    = 1'b0;
                        fault_d = 1'b1;
                        state_d = StFault;
                    end
                end
            end
            StFault: begin
                // Faulting instruction is dropped; pc stays visible for the handler.
                pc_d     = iw_pc;
                instr_d  = iw_instr;
                opc_d    = OPC_NOP;
                tgt_gp_d = '0;
                tgt_sr_d = '0;
                result_d = '0;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Upstream must not see a stall while the stage is held in reset.
        if (iw_rst) begin
            stall = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            state_q  <= StIdle;
            pc_q     <= '0;
            instr_q  <= '0;
            opc_q    <= '0;
            tgt_gp_q <= '0;
            tgt_sr_q <= '0;
            result_q <= '0;
            fault_q  <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            opc_q    <= opc_d;
            tgt_gp_q <= tgt_gp_d;
            tgt_sr_q <= tgt_sr_d;
            result_q <= result_d;
            fault_q  <= fault_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign ow_pc        = pc_q;
    assign ow_instr     = instr_q;
    assign ow_opc       = opc_q;
    assign ow_tgt_gp    = tgt_gp_q;
    assign ow_tgt_sr    = tgt_sr_q;
    assign ow_result    = result_q;
    assign ow_stall     = stall;
    assign ow_fault     = fault_q;
    assign ow_mem_req   = req_q;
    assign ow_mem_we    = we_q;
    assign ow_mem_addr  = addr_q;
    assign ow_mem_wdata = wdata_q;

endmodule

// File: doc/stg4ma.md
Name: stg4ma

Overview:
Memory-access pipeline stage. It sits directly downstream of the execute stage and upstream of write-back. It consumes the execute-stage latched outputs (pc, instr, opc, target indices, result):
- non-memory ops pass through with one-cycle latency;
- OPC_M_LD / OPC_M_ST run a req/ack transaction on the data-memory port, stall the upstream pipeline until completion, and abort on timeout.

Parameters:
SIZE_DATA, 24, data/result width
SIZE_ADDR, 24, memory address width (address = low SIZE_ADDR bits of iw_result)
SIZE_OPC, 8, opcode width
SIZE_TGT_GP, 4, GP target index width
SIZE_TGT_SR, 2, SR target index width
TIMEOUT, 16, max WAIT cycles before abort (≥1)

Ports:
iw_clk  in  1  clock
iw_rst  in  1  reset, synchronous, active-high
iw_pc  in  SIZE_ADDR  pc from execute
iw_instr  in  SIZE_DATA  instruction word from execute
iw_opc  in  SIZE_OPC  opcode from execute
iw_tgt_gp  in  SIZE_TGT_GP  GP target from execute
iw_tgt_sr  in  SIZE_TGT_SR  SR target from execute
iw_result  in  SIZE_DATA  ALU result (memory address for LD/ST)
iw_st_data  in  SIZE_DATA  store data (GP read of target register)
ow_pc / ow_instr / ow_opc / ow_tgt_gp / ow_tgt_sr  out  as inputs  registered to write-back
ow_result  out  SIZE_DATA  registered result (load data for LD)
ow_stall  out  1  combinational; upstream holds its registers while high
ow_fault  out  1  registered one-cycle pulse on memory timeout
ow_mem_req  out  1  registered request
ow_mem_we  out  1  registered; 1 = store
ow_mem_addr  out  SIZE_ADDR  registered address
ow_mem_wdata  out  SIZE_DATA  registered store data
iw_mem_ack  in  1  memory done; valid only while ow_mem_req=1
iw_mem_rdata  in  SIZE_DATA  load data, valid with ack

Behaviour:
- Reset (synchronous): all outputs 0, state IDLE, timeout counter 0. Reset during WAIT drops ow_mem_req at the same edge and discards the transaction. No fault is raised.
- is_mem = (iw_opc==OPC_M_LD) || (iw_opc==OPC_M_ST).
- States: IDLE, WAIT, FAULT.
- IDLE, !is_mem:
  - output regs <= inputs (result <= iw_result); 1-cycle latency; ow_stall=0.
- IDLE, is_mem:
  - ow_stall=1.
  - Output regs <= bubble: opc=OPC_NOP(0), tgt_gp=0, tgt_sr=0, result=0; pc/instr still copied.
  - ow_mem_req<=1; ow_mem_we<=(opc==ST); ow_mem_addr<=iw_result[SIZE_ADDR-1:0]; ow_mem_wdata<=iw_st_data; counter<=0; state->WAIT.
- WAIT, !iw_mem_ack:
  - ow_stall=1; bubble output; counter++.
  - If counter==TIMEOUT-1: req<=0, state->FAULT.
- WAIT, iw_mem_ack:
  - ow_stall=0 (upstream advances at this edge).
  - Output regs <= held inputs; result <= iw_mem_rdata for LD, iw_result for ST.
  - req<=0, we<=0; state->IDLE.
  - Ack on the timeout cycle: ack wins, no fault.
- FAULT (one cycle):
  - ow_fault=1 registered for this cycle.
  - Output bubble; ow_pc <= faulting pc; ow_stall=0 (the faulting instruction is dropped).
  - state->IDLE.
- iw_mem_ack while ow_mem_req=0 is ignored.
- Inputs are stable during stall (upstream contract). The address is captured once in IDLE; the memory port is held constant until ack or timeout.
- Back-to-back mem ops: after ack the next op is seen in IDLE one cycle later, so there is a minimum one idle cycle of req=0 between transactions.
- Store issues no register write: ow_opc=OPC_M_ST, and write-back must ignore it.

Decomposition:
- Shared package/header: SIZE_* widths, OPC_NOP, OPC_M_LD, OPC_M_ST, state encodings (IDLE=0, WAIT=1, FAULT=2).
- One natural sub-module, ma_timeout_ctr: counter with clear/enable/expired, parameterised by TIMEOUT. FSM and pipeline latch stay in stg4ma.

Test Plan:
- ADD passthrough: opc=ADD, result=0x000123, tgt_gp=3 -> next cycle ow_opc=ADD, ow_result=0x000123, ow_tgt_gp=3, ow_stall never high.
- Load, ack after 3 cycles: opc=LD, result=0x000040, rdata=0xABCDEF -> req=1, we=0, addr=0x000040. ow_stall high 4 cycles, bubbles out, then ow_result=0xABCDEF with ow_opc=LD.
- Store, immediate ack: opc=ST, result=0x000010, st_data=0x55AA55 -> req=1, we=1, wdata=0x55AA55 for 1 cycle. ow_result=0x000010, ow_opc=ST.
- Timeout, TIMEOUT=4, no ack: req high 4 cycles, then drops. ow_fault=1 for one cycle with ow_pc=faulting pc, ow_opc=0, then stall released.
- Reset mid-WAIT at cycle 2: req=0, ow_stall=0 after the edge, all outputs 0. A later spurious ack produces no output change.
- LD immediately followed by ADD: ADD is held during stall, emerges exactly one cycle after the LD result. A spurious ack in IDLE is ignored.
